// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between four requesters and the rr_arbiter4 arbiter.
// master: requester side (drives req/done, observes the grant).
// slave : arbiter side (samples req/done, drives the grant signals).
interface rr_arbiter4_if;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with a registered one-hot grant.
// A grant is held until the owner releases it (done, or dropping its
// request), and every grant is followed by one mandatory idle cycle.
// Optional macro ARB_TIMEOUT_EN: bounds any grant to MAX_HOLD cycles and
// pulses timeout on a forced release. Without it, grants are unbounded
// and timeout is tied low.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter4_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] idx_q, idx_d;
  logic [2:0] pick;
  logic       normal_rel;
  logic       force_rel;

  // Elaboration-time guard on the hold limit.
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arbiter4: MAX_HOLD out of range 2..255");
  end

  // Round-robin search: first set request starting at p, wrapping mod 4.
  // Returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [2:0] res;
    logic [1:0] c;
    res = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      c = p + 2'(k);
      if (r[c]) res = {1'b1, c};
    end
    return res;
  endfunction

  assign pick       = rr_pick(bus.req, ptr_q);
  assign normal_rel = bus.done | ~bus.req[idx_q];

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  logic [CNT_W-1:0] hold_q;
  logic             timeout_q, timeout_d;

  assign force_rel = (hold_q == CNT_W'(MAX_HOLD - 1));

  // Hold counter: zero in IDLE (so it is clear on grant entry), counts GRANT cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
    end else if (state_q == GRANT) begin
      hold_q <= hold_q + 1'b1;
    end else begin
      hold_q <= '0;
    end
  end

  // Timeout pulse only when the counter alone caused the release.
  always_comb begin
    timeout_d = 1'b0;
    if (state_q == GRANT && !normal_rel && force_rel) timeout_d = 1'b1;
  end

  // Registered timeout strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign force_rel   = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // Next-state and next-output logic for the IDLE/GRANT controller.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (pick[2]) begin
          state_d = GRANT;
          gnt_d   = 4'b0001 << pick[1:0];
          idx_d   = pick[1:0];
        end
      end
      GRANT: begin
        // done and a dropped request together still count as one release.
        if (normal_rel || force_rel) begin
          state_d = IDLE;
          gnt_d   = 4'b0000;
          ptr_d   = idx_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // State, pointer and grant registers; reset drops any grant at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_idx   = idx_q;
  assign bus.gnt_valid = (state_q == GRANT);

endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: directed scenarios with literal expectations plus
// a randomized phase, all checked every cycle against a behavioural model.
module tb_rr_arbiter4;

`ifdef ARB_TIMEOUT_EN
  localparam int MH = 4;
  localparam bit TO_EN = 1'b1;
`else
  localparam int MH = 16;
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  rr_arbiter4_if bif ();

  rr_arbiter4 #(.MAX_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  // Behavioural model: who owns the resource, whose turn is next,
  // and how many cycles the current owner has held it.
  int   m_owner = -1;
  int   m_ptr   = 0;
  int   m_idx   = 0;
  int   m_hold  = 0;
  logic m_to    = 1'b0;

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_idx = 0; m_hold = 0; m_to = 1'b0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic d);
    bit rel, to;
    m_to = 1'b0;
    if (m_owner < 0) begin
      for (int k = 0; k < 4; k++) begin
        int i;
        i = (m_ptr + k) % 4;
        if (r[i]) begin
          m_owner = i; m_idx = i; m_hold = 1;
          break;
        end
      end
    end else begin
      rel = d || !r[m_owner];
      to  = TO_EN && (m_hold >= MH);
      if (rel || to) begin
        m_ptr   = (m_owner + 1) % 4;
        m_owner = -1;
        m_to    = to && !rel;
      end else begin
        m_hold++;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step(bif.req, bif.done);
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      logic [3:0] eg;
      @(negedge clk);
      eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
      checks++;
      if (bif.gnt !== eg || bif.gnt_valid !== (m_owner >= 0) ||
          bif.gnt_idx !== 2'(m_idx) || bif.timeout !== m_to ||
          $countones(bif.gnt) > 1) begin
        errors++;
        $display("FAIL model t=%0t gnt=%b/%b idx=%0d/%0d valid=%b/%b timeout=%b/%b",
                 $time, bif.gnt, eg, bif.gnt_idx, m_idx, bif.gnt_valid,
                 (m_owner >= 0), bif.timeout, m_to);
      end
    end
  end

  task automatic lit(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    logic to_seen;
    bif.req = 4'b0000; bif.done = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    lit("reset_gnt", {4'b0, bif.gnt}, 8'h00);
    lit("reset_valid", {7'b0, bif.gnt_valid}, 8'h00);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Single requester, release, re-grant after one idle cycle.
    bif.req = 4'b0100;
    tick();
    lit("single_gnt", {4'b0, bif.gnt}, 8'b0100);
    lit("single_idx", {6'b0, bif.gnt_idx}, 8'd2);
    bif.done = 1'b1;
    tick();
    lit("single_rel", {4'b0, bif.gnt}, 8'b0000);
    bif.done = 1'b0;
    tick();
    lit("single_regrant", {4'b0, bif.gnt}, 8'b0100);

    // Asynchronous reset in the middle of a grant.
    #2 rst_n = 1'b0;
    #1;
    lit("async_rst_gnt", {4'b0, bif.gnt}, 8'b0000);
    lit("async_rst_valid", {7'b0, bif.gnt_valid}, 8'h00);
    lit("async_rst_to", {7'b0, bif.timeout}, 8'h00);
    bif.req = 4'b1111;
    #1 rst_n = 1'b1;
    tick();
    lit("after_rst_gnt", {4'b0, bif.gnt}, 8'b0001);
    lit("after_rst_idx", {6'b0, bif.gnt_idx}, 8'd0);

    // Round robin, 3 cycles held + 1 idle.
    for (int g = 0; g < 5; g++) begin
      lit("rr_idx", {6'b0, bif.gnt_idx}, 8'(g % 4));
      lit("rr_valid", {7'b0, bif.gnt_valid}, 8'h01);
      tick(); tick();
      bif.done = 1'b1;
      tick();
      bif.done = 1'b0;
      lit("rr_gap", {4'b0, bif.gnt}, 8'b0000);
      tick();
    end
    // Now owner 1 is granted (ptr was 1); release it to reach a known ptr.
    bif.req = 4'b1000;
    tick();
    tick();
    lit("wrap_owner3", {4'b0, bif.gnt}, 8'b1000);

    // Owner 3 releases (done and request drop together) with req=0101.
    bif.req = 4'b0101; bif.done = 1'b1;
    tick();
    bif.done = 1'b0;
    tick();
    lit("wrap_gnt0", {4'b0, bif.gnt}, 8'b0001);
    bif.done = 1'b1;
    tick();
    bif.done = 1'b0;
    tick();
    lit("skip_gnt2", {4'b0, bif.gnt}, 8'b0100);

    // Request drop: owner 1 drops its request, next search starts at 2.
    bif.req = 4'b0010; bif.done = 1'b1;
    tick();
    bif.done = 1'b0;
    tick();
    lit("drop_owner1", {4'b0, bif.gnt}, 8'b0010);
    bif.req = 4'b0000;
    tick();
    lit("drop_rel", {4'b0, bif.gnt}, 8'b0000);
    bif.req = 4'b0011;
    tick();
    lit("drop_order", {4'b0, bif.gnt}, 8'b0001);

    // Hold test: single continuous requester, no done.
    bif.req = 4'b0000;
    tick();
    bif.req = 4'b0001;
    tick();
    cnt = 0; to_seen = 1'b0;
    for (int i = 0; i < 120; i++) begin
      if (bif.gnt == 4'b0001) cnt++;
      else begin
        to_seen = bif.timeout;
        break;
      end
      tick();
    end
`ifdef ARB_TIMEOUT_EN
    lit("timeout_len", 8'(cnt), 8'd4);
    lit("timeout_pulse", {7'b0, to_seen}, 8'h01);
`else
    lit("unbounded_len", 8'(cnt), 8'd120);
    lit("no_timeout", {7'b0, bif.timeout}, 8'h00);
`endif

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      bif.req  = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) bif.req = bif.req | 4'b0001 << $urandom_range(0, 3);
      bif.done = ($urandom_range(0, 5) == 0);
      tick();
    end
    bif.req = 4'b0000; bif.done = 1'b0;
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
Name: rr_arbiter4

Overview:
- Four-requester round-robin arbiter that shares one downstream resource.
- Produces a registered one-hot grant plus a 2-bit encoded grant index.
- Index mapping is fixed: requester 0 -> 00, 1 -> 01, 2 -> 10, 3 -> 11.
- Sits in front of the shared resource; grant is held until the owner releases it.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one requester may hold the grant. Used only when ARB_TIMEOUT_EN is defined. Legal range is 2..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req  input  4  request lines; req[i]=1 means requester i wants the resource.
- done  input  1  current owner's release strobe; sampled only in GRANT.
- gnt  output  4  registered one-hot grant; all zero when idle.
- gnt_idx  output  2  encoded index of the current owner; holds its last value when idle.
- gnt_valid  output  1  high while any grant is active; equals OR of gnt.
- timeout  output  1  one-cycle pulse on a forced release.

Behaviour:
- Reset (async, rst_n=0):
  - gnt=0000, gnt_idx=00, gnt_valid=0, timeout=0.
  - Round-robin pointer ptr=0; state=IDLE; hold counter=0.
  - Reset asserted mid-grant drops the grant immediately, with no clock needed.
- States: IDLE, GRANT. All outputs are registered.
- IDLE:
  - If req != 0, select the first set bit searching ptr, ptr+1, ... modulo 4.
  - Next edge: gnt=onehot(sel), gnt_idx=sel, gnt_valid=1, state=GRANT.
  - Latency is 1 cycle from req sampled to gnt visible.
  - If req == 0, remain in IDLE; outputs unchanged except gnt=0.
- GRANT:
  - Hold the grant while req[gnt_idx]=1 and done=0.
  - Other requesters are ignored; there is no preemption.
  - Release condition: done=1, or req[gnt_idx]=0, or a timeout (see Optional Feature).
  - On release edge: gnt=0000, gnt_valid=0, ptr=gnt_idx+1 (2-bit wrap, so 3 -> 0), state=IDLE.
  - gnt_idx keeps the old value.
- One mandatory idle cycle between consecutive grants, even if requests are pending.
- Simultaneous done=1 and req[owner]=0 is a single release; ptr advances once.
- done asserted in IDLE is ignored.
- Arbitration order example: with ptr=2 and req=1011, requester 3 wins.
- Fairness: with all four requesting continuously and each released after N cycles, the grant order is 0,1,2,3,0,... The grant period is N+1 cycles per requester, including the idle gap.
- gnt never has more than one bit set. gnt_valid=1 if and only if state=GRANT.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - A hold counter of width clog2(MAX_HOLD+1) clears on grant entry and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD-1 and no other release condition applies, the next edge forces a release.
  - On that edge timeout=1 for exactly one cycle; ptr advances as for a normal release.
  - If done and the timeout occur in the same cycle, it is treated as a normal release with timeout=0.
  - Total grant length is at most MAX_HOLD cycles.
- Not defined: no counter is synthesized; timeout is tied to 0; grants are unbounded.

Test Plan:
- Reset check: rst_n=0 pulsed mid-grant (gnt=0100) -> gnt=0000, gnt_valid=0, timeout=0 immediately. After release, req=1111 -> requester 0 granted first (gnt=0001, gnt_idx=00).
- Single requester: req=0100 -> gnt=0100, gnt_idx=10 one cycle later. done pulse -> gnt=0000 next cycle. With req still 0100, re-granted after one idle cycle.
- Round-robin: req=1111 held, done pulsed on each grant's 3rd cycle -> gnt_idx sequence 00,01,10,11,00 with a 4-cycle period (3 held + 1 idle).
- Wrap and skip: owner 3 releases with req=0101 -> gnt=0001 (ptr wrapped to 0). Then ptr=1, req=0101 -> gnt=0100.
- Request drop: owner 1 with req 0010 -> 0000, no done -> gnt=0000 next edge, ptr=2. Then req=0011 -> gnt=0001 (search order 2,3,0).
- Timeout (ARB_TIMEOUT_EN, MAX_HOLD=4): req=0001 held, done=0 -> gnt high exactly 4 cycles, timeout=1 on the release edge. Without the macro, the grant persists for 100+ cycles and timeout stays 0.
